reg_access_ctrl: RTL
====================

// Module: reg_access_ctrl
// PURPOSE
//  Shares one W-bit enable-clear register among NUM_REQ requesters through a round-robin controller.
//  - Register semantics: on each posedge clk, en=0 clears it; en=1 loads d.
//  - This block drives the register's en/d every cycle:
//    - hold: en=1, d=q
//    - write: en=1, d=wdata
//    - clear: en=0
//  - Sits between requester blocks and the shared register; completes one access per grant.
// PARAMETERS
//  W        4  register width, bits
//  NUM_REQ  4  number of requesters, 2..8
// PORTS
//  clk      in   1          system clock, posedge
//  rst_n    in   1          asynchronous active-low reset
//  req      in   NUM_REQ    request per requester; hold high until its ack
//  op       in   NUM_REQ    per requester: 1=write wdata, 0=clear register
//  wdata    in   NUM_REQ*W  write data; slice i = wdata[i*W +: W]
//  gnt      out  NUM_REQ    one-hot grant, registered
//  ack      out  NUM_REQ    one-hot 1-cycle completion pulse
//  busy     out  1          high in GRANT or ACK state
//  reg_en   out  1          to register en; 0 = clear at next edge
//  reg_d    out  W          to register d
//  reg_q    in   W          register q, fed back for hold
//  rdata    out  W          register value after the access; valid while ack
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - State=IDLE; gnt=0, ack=0, busy=0, rdata=0; rr pointer=0.
//   - reg_en=0, reg_d=0, so the register is cleared at every clk edge during reset.
//  State IDLE
//   - reg_en=1, reg_d=reg_q (hold).
//   - If any req: pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
//   - At the edge: latch index, op and data; set gnt[idx]; go to GRANT.
//  State GRANT
//   - busy=1.
//   - op=1: reg_en=1, reg_d=latched data.
//   - op=0: reg_en=0, reg_d=0.
//   - Register updates at this edge; go to ACK.
//  State ACK
//   - busy=1, ack[idx]=1, rdata=reg_q (updated value), reg_en=1, reg_d=reg_q.
//   - At the edge: gnt=0, pointer=(idx+1) mod NUM_REQ, go to IDLE.
//  Timing
//   - req sampled at edge k -> gnt high after k, register written at k+1, ack high between k+1 and k+2.
//   - Minimum 3 cycles per access, including 1 IDLE cycle; no back-to-back grants.
//  Boundary cases
//   - Simultaneous requests: exactly one grant; others wait. Every requester is served within NUM_REQ accesses.
//   - req dropped after grant: the access still completes and is acked (data was latched at grant).
//   - req still high in IDLE after its ack: treated as a new request; the pointer has moved past that requester.
//   - op/wdata changes after grant: ignored.
//   - Pointer wrap: after idx=NUM_REQ-1 the pointer goes to 0.
//   - Reset mid-access: abort immediately; no ack; register cleared; state=IDLE.
//   - gnt and ack are never multi-hot. ack is never high without the matching gnt.
// STRUCTURE
//  - Shared package holds:
//    - state encoding ST_IDLE=2'd0, ST_GRANT=2'd1, ST_ACK=2'd2
//    - op encoding OP_CLR=1'b0, OP_WR=1'b1
//  - One sub-module: rr_arbiter.
//    - Combinational; inputs req and pointer; outputs one-hot grant and index.
//  - FSM, latches and register drive stay in reg_access_ctrl.
// TESTING  (W=4, NUM_REQ=4)
//  1. Reset: rst_n=0 with reg_q=4'hA -> reg_en=0, gnt=0, ack=0; register reads 0 after one edge.
//  2. Write: req=0001, op[0]=1, wdata[3:0]=4'h5 -> gnt=0001 next cycle; reg_d=5 and reg_en=1 in GRANT; ack=0001, rdata=5 in ACK.
//  3. Clear: register=4'h5; req=0100, op[2]=0 -> reg_en=0 in GRANT; ack=0100, rdata=0.
//  4. Fairness: req=1111 held, data 1/2/3/4 -> grant order 0,1,2,3,0; rdata 1,2,3,4,1; acks 3 cycles apart.
//  5. Hold: idle for 10 cycles with register=4'h9 -> reg_en=1, reg_d=9 every cycle; value unchanged.
//  6. Abort: rst_n=0 pulsed during GRANT of a write of 4'hF -> no ack; register=0; next request is served normally, starting with pointer=0.

Source files
------------

// File: rtl/reg_access_ctrl_pkg.sv
// rtl/reg_access_ctrl_pkg.sv - shared encodings for the round-robin register access controller
package reg_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_WR  = 1'b1;

endpackage

// File: rtl/reg_access_ctrl_rr_arbiter.sv
// rtl/reg_access_ctrl_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!any && req[c]) begin
                any      = 1'b1;
                idx      = IW'(c);
                grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - shares one enable-clear register among NUM_REQ requesters, one access per grant
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int W       = 4,
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   op,
    input  logic [NUM_REQ*W-1:0] wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic                 reg_en,
    output logic [W-1:0]         reg_d,
    input  logic [W-1:0]         reg_q,
    output logic [W-1:0]         rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       lat_idx;
    logic                lat_op;
    logic [W-1:0]        lat_data;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            ack      <= '0;
            ptr      <= '0;
            lat_idx  <= '0;
            lat_op   <= OP_CLR;
            lat_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        lat_idx  <= arb_idx;
                        lat_op   <= op[arb_idx];
                        lat_data <= wdata[arb_idx*W +: W];
                        gnt      <= arb_gnt;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    ack   <= gnt;
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    gnt   <= '0;
                    ack   <= '0;
                    ptr   <= (lat_idx == IW'(NUM_REQ - 1)) ? '0 : lat_idx + IW'(1);
                    state <= ST_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Register drive follows reset directly so the register clears on every edge while held in reset.
    always_comb begin
        reg_en = 1'b1;
        reg_d  = reg_q;
        rdata  = '0;
        if (!rst_n) begin
            reg_en = 1'b0;
            reg_d  = '0;
        end else begin
            case (state)
                ST_GRANT: begin
                    if (lat_op == OP_WR) begin
                        reg_d = lat_data;
                    end else begin
                        reg_en = 1'b0;
                        reg_d  = '0;
                    end
                end
                ST_ACK:  rdata = reg_q;
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_GRANT) || (state == ST_ACK);

endmodule
